glbl_reg_arb: RTL

Register-bus arbiter that shares the single global-config register port (6-bit word-aligned address, 32-bit data, byte enables, cs/wr/ack handshake) between up to four bus masters, e.g. the Wishbone host bridge and the debug UART master. It sits directly in front of the global config register block:
- it latches one master's request and issues it to the slave as a registered single-cycle-ack transaction;
- it returns read data and ack to that master;
- it recovers from a missing slave ack by timeout.

Grants are round-robin. One transaction is outstanding at a time.

---
 rtl/glbl_pkg.sv | 8 +
 rtl/glbl_rr_sel.sv | 28 ++
 rtl/glbl_reg_arb.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/glbl_pkg.sv
// rtl/glbl_pkg.sv - shared types and constants for the global-config register arbiter
package glbl_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, ACK} arb_state_t;

    localparam logic [31:0] TMO_RDATA = 32'hDEAD_0BAD;
    localparam int REG_AW = 6;
    localparam int REG_DW = 32;
endpackage

// File: rtl/glbl_rr_sel.sv
// rtl/glbl_rr_sel.sv - combinational round-robin picker, search starts after last
module glbl_rr_sel #(
    parameter int NM = 2
) (
    input  logic [NM-1:0] req,
    input  logic [1:0]    last,
    output logic          gnt_vld,
    output logic [1:0]    gnt_idx
);
    logic [3:0] req_pad;
    logic [1:0] idx;

    assign req_pad = 4'(req);

    // The first hit at distance 1..NM from last wins, so last itself is checked last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NM; k++) begin
            idx = 2'((3'(last) + 3'(k)) % 3'(NM));
            if (!gnt_vld && req_pad[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end
endmodule

// File: rtl/glbl_reg_arb.sv
// rtl/glbl_reg_arb.sv - round-robin arbiter sharing the global-config register port
module glbl_reg_arb
    import glbl_pkg::*;
#(
    parameter int NM      = 2,
    parameter int TMO_CYC = 64
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic [NM-1:0]        m_cs,
    input  logic [NM-1:0]        m_wr,
    input  logic [NM*REG_AW-1:0] m_addr,
    input  logic [NM*REG_DW-1:0] m_wdata,
    input  logic [NM*4-1:0]      m_be,
    output logic [REG_DW-1:0]    m_rdata,
    output logic [NM-1:0]        m_ack,
    output logic [NM-1:0]        m_err,
    output logic                 reg_cs,
    output logic                 reg_wr,
    output logic [REG_AW-1:0]    reg_addr,
    output logic [REG_DW-1:0]    reg_wdata,
    output logic [3:0]           reg_be,
    input  logic [REG_DW-1:0]    reg_rdata,
    input  logic                 reg_ack,
    output logic                 busy,
    output logic [1:0]           gnt_id
);
    arb_state_t state, state_nx;
    logic [7:0] cnt;
    logic [1:0] last_gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic       grant, done, tmo;
    logic [NM-1:0] hit;

    logic              sel_wr;
    logic [REG_AW-1:0] sel_addr;
    logic [REG_DW-1:0] sel_wdata;
    logic [3:0]        sel_be;

    glbl_rr_sel #(.NM(NM)) u_rr_sel (
        .req     (m_cs),
        .last    (last_gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel_wr    = m_wr[i];
                sel_addr  = m_addr[i*REG_AW +: REG_AW];
                sel_wdata = m_wdata[i*REG_DW +: REG_DW];
                sel_be    = m_be[i*4 +: 4];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NM; i++) begin
            hit[i] = (gnt_id == 2'(i));
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // A slave ack in the final count cycle takes priority over the timeout.
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        done     = 1'b0;
        tmo      = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    grant    = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (reg_ack) begin
                    done     = 1'b1;
                    state_nx = ACK;
                end else if (cnt == 8'(TMO_CYC - 1)) begin
                    done     = 1'b1;
                    tmo      = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            last_gnt  <= 2'(NM - 1);
            gnt_id    <= '0;
            busy      <= 1'b0;
            m_rdata   <= '0;
            m_ack     <= '0;
            m_err     <= '0;
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_be    <= '0;
        end else begin
            m_ack <= '0;
            m_err <= '0;
            busy  <= (state_nx != IDLE);
            if (state == BUSY) cnt <= cnt + 8'd1;
            if (grant) begin
                reg_cs    <= 1'b1;
                reg_wr    <= sel_wr;
                reg_addr  <= sel_addr;
                reg_wdata <= sel_wdata;
                reg_be    <= sel_be;
                gnt_id    <= gnt_idx;
                cnt       <= '0;
            end
            if (done) begin
                reg_cs   <= 1'b0;
                m_rdata  <= tmo ? TMO_RDATA : (reg_wr ? '0 : reg_rdata);
                m_ack    <= hit;
                m_err    <= tmo ? hit : '0;
                last_gnt <= gnt_id;
            end
        end
    end
endmodule
